instr_mem_loader: RTL and testbench
===================================

// Module: instr_mem_loader
// PURPOSE
//  Writer side of the instruction fetch path. It accepts instruction fields
//  (opcode, addrA, addrB, addrW) one beat at a time over a valid/ready
//  handshake and encodes each beat into a 20-bit word:
//    [4:0] opcode, [9:5] addrA, [14:10] addrB, [19:15] addrW.
//  Words are stored in consecutive slots of an internal 32x20 instruction
//  store, which is presented whole on mem for the fetch stage to index.
// PARAMETERS
//  DEPTH          32  number of instruction slots; must be 32 to match the 5-bit fetch index
//  FIELD_W         5  width of each instruction field
//  WORD_W         20  stored word width; must equal 4*FIELD_W
//  CLEAR_ON_START  1  1: zero the whole store when a load starts; 0: keep the old contents
// PORTS
//  clk        in   1            rising-edge clock
//  rst_n      in   1            asynchronous reset, active low
//  start      in   1            begin a new load at slot 0; 1-cycle pulse
//  ld_valid   in   1            a field beat is presented
//  ld_ready   out  1            loader can accept a beat
//  ld_opcode  in   5            opcode field
//  ld_addrA   in   5            source A register address
//  ld_addrB   in   5            source B register address
//  ld_addrW   in   5            destination register address
//  ld_last    in   1            marks the final beat of the program
//  mem        out  [31:0][19:0] instruction store, packed, slot-indexed
//  count      out  6            number of words written since the last start (0..32)
//  done       out  1            high while in DONE
//  overflow   out  1            sticky: store filled with no ld_last seen
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - all mem words 0; count=0; done=0; overflow=0; state=IDLE; ld_ready=0.
//  States: IDLE, LOAD, DONE. State and write pointer are registered.
//  ld_ready = (state==LOAD) && !start. A beat is accepted when ld_valid && ld_ready.
//  IDLE:
//   - start -> LOAD; ptr=0, count=0, overflow=0; store cleared if CLEAR_ON_START.
//  LOAD:
//   - On accept: mem[ptr] <= {addrW,addrB,addrA,opcode}; ptr++; count++.
//     The written word is visible on mem the next cycle (1-cycle latency).
//   - Accept with ld_last=1 -> DONE.
//   - Accept at ptr==31 with ld_last=0 -> word 31 is written, overflow<=1, -> DONE.
//   - start in LOAD -> restart: ptr=0, count=0, overflow=0, optional clear.
//     No beat is accepted in that cycle (ready is low); state stays LOAD.
//   - ld_valid may drop at any time; no accept and no state change.
//  DONE:
//   - done=1; ld_ready=0; contents held.
//   - start -> LOAD, with the same actions as from IDLE.
//  Pointer never wraps; at most 32 writes per load. count saturates at 32.
//  Reset asserted mid-load aborts immediately; partial contents are lost (zeroed).
//  mem, count and flags are driven from registers only; no combinational path
//  from ld_* to mem.
// TESTING
//  1 Reset, start, 3 beats (op=1,A=2,B=3,W=4; ...), last on beat 3
//    -> mem[0]=20'h20C41, count=3, done=1 one cycle after beat 3; mem[3..31]=0.
//  2 32 beats with no ld_last -> all 32 slots written, overflow=1, done=1,
//    ld_ready=0; a 33rd valid beat is not accepted.
//  3 In LOAD, start and ld_valid asserted together -> ld_ready=0 that cycle,
//    count=0, ptr=0; the next accepted beat lands in mem[0].
//  4 ld_valid toggled randomly over 10 beats -> only handshaked beats are
//    stored, in order; count=10.
//  5 rst_n pulsed low for a fraction of a cycle after 5 accepted beats
//    -> mem all 0, state IDLE, count=0 immediately (async, no clock needed).
//  6 CLEAR_ON_START=0: load 4 words, then start and load 2
//    -> slots 0-1 hold the new words, slots 2-3 keep the old ones, count=2.

Source files
------------

// File: rtl/instr_mem_loader.sv
// Instruction store writer: accepts field beats over valid/ready, packs them into
// 20-bit words and fills consecutive slots of a 32-entry store presented on mem.
module instr_mem_loader #(
    parameter int unsigned DEPTH          = 32,
    parameter int unsigned FIELD_W        = 5,
    parameter int unsigned WORD_W         = 20,
    parameter bit          CLEAR_ON_START = 1'b1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic                             ld_valid,
    output logic                             ld_ready,
    input  logic [FIELD_W-1:0]               ld_opcode,
    input  logic [FIELD_W-1:0]               ld_addrA,
    input  logic [FIELD_W-1:0]               ld_addrB,
    input  logic [FIELD_W-1:0]               ld_addrW,
    input  logic                             ld_last,
    output logic [DEPTH-1:0][WORD_W-1:0]     mem,
    output logic [$clog2(DEPTH):0]           count,
    output logic                             done,
    output logic                             overflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [PTR_W-1:0]   ptr;
    logic               accept;
    logic               last_slot;
    logic [WORD_W-1:0]  word;

    assign ld_ready  = (state == LOAD) && !start;
    assign accept    = ld_valid && ld_ready;
    assign last_slot = (ptr == PTR_W'(DEPTH - 1));
    assign word      = WORD_W'({ld_addrW, ld_addrB, ld_addrA, ld_opcode});
    assign done      = (state == DONE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a start always (re)enters LOAD
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) state_nxt = LOAD;
            end
            LOAD: begin
                if (accept && (ld_last || last_slot)) state_nxt = DONE;
            end
            DONE: begin
                if (start) state_nxt = LOAD;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Store, write pointer, word count and overflow flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem      <= '0;
            ptr      <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (start) begin
            ptr      <= '0;
            count    <= '0;
            overflow <= 1'b0;
            if (CLEAR_ON_START) mem <= '0;
        end else if (accept) begin
            mem[ptr] <= word;
            // Pointer parks on the last slot instead of wrapping
            if (!last_slot) ptr <= ptr + PTR_W'(1);
            if (count != CNT_W'(DEPTH)) count <= count + CNT_W'(1);
            if (last_slot && !ld_last) overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: two instances (store cleared / kept on start)
// share stimulus; a reference model and word scoreboard supply every expected value.
module tb_instr_mem_loader;

    logic clk = 1'b0;
    logic rst_n;
    logic start, ld_valid, ld_last;
    logic [4:0] ld_opcode, ld_addrA, ld_addrB, ld_addrW;
    logic ready1, ready2, done1, done2, ovf1, ovf2;
    logic [5:0] cnt1, cnt2;
    logic [31:0][19:0] mem1, mem2;

    always #5 clk = ~clk;

    instr_mem_loader #(.CLEAR_ON_START(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ld_valid(ld_valid), .ld_ready(ready1),
        .ld_opcode(ld_opcode), .ld_addrA(ld_addrA), .ld_addrB(ld_addrB), .ld_addrW(ld_addrW),
        .ld_last(ld_last), .mem(mem1), .count(cnt1), .done(done1), .overflow(ovf1)
    );

    instr_mem_loader #(.CLEAR_ON_START(1'b0)) dut_keep (
        .clk(clk), .rst_n(rst_n), .start(start), .ld_valid(ld_valid), .ld_ready(ready2),
        .ld_opcode(ld_opcode), .ld_addrA(ld_addrA), .ld_addrB(ld_addrB), .ld_addrW(ld_addrW),
        .ld_last(ld_last), .mem(mem2), .count(cnt2), .done(done2), .overflow(ovf2)
    );

    typedef struct {
        int          idx;
        logic [19:0] word;
    } sb_t;

    sb_t         sb[$];
    logic [19:0] m_mem1 [32];
    logic [19:0] m_mem2 [32];
    int          m_state;
    int          m_ptr;
    int          m_cnt;
    logic        m_ovf;
    int          tests = 0;
    int          fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_mem1[i] = '0;
            m_mem2[i] = '0;
        end
        m_state = 0;
        m_ptr   = 0;
        m_cnt   = 0;
        m_ovf   = 1'b0;
        sb.delete();
    endtask

    task automatic check_flags(input string tag);
        chk({tag, ".count"}, 32'(cnt1), 32'(m_cnt));
        chk({tag, ".count_keep"}, 32'(cnt2), 32'(m_cnt));
        chk({tag, ".done"}, 32'(done1), 32'(m_state == 2));
        chk({tag, ".done_keep"}, 32'(done2), 32'(m_state == 2));
        chk({tag, ".overflow"}, 32'(ovf1), 32'(m_ovf));
        chk({tag, ".overflow_keep"}, 32'(ovf2), 32'(m_ovf));
    endtask

    task automatic check_mem(input string tag);
        for (int i = 0; i < 32; i++) begin
            chk($sformatf("%s.mem[%0d]", tag, i), 32'(mem1[i]), 32'(m_mem1[i]));
            chk($sformatf("%s.mem_keep[%0d]", tag, i), 32'(mem2[i]), 32'(m_mem2[i]));
        end
    endtask

    task automatic drain_sb(input string tag);
        sb_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk($sformatf("%s.sb[%0d]", tag, e.idx), 32'(mem1[e.idx]), 32'(e.word));
        end
    endtask

    // One clock of stimulus: drive on the falling edge, check ready, update the model
    task automatic step(input logic v, input logic st, input logic last,
                        input logic [4:0] op, input logic [4:0] a,
                        input logic [4:0] b, input logic [4:0] w);
        logic        exp_rdy;
        logic [19:0] wd;
        sb_t         e;
        @(negedge clk);
        ld_valid = v; start = st; ld_last = last;
        ld_opcode = op; ld_addrA = a; ld_addrB = b; ld_addrW = w;
        #1;
        exp_rdy = (m_state == 1) && !st;
        chk("ld_ready", 32'(ready1), 32'(exp_rdy));
        chk("ld_ready_keep", 32'(ready2), 32'(exp_rdy));
        @(posedge clk);
        #1;
        if (st) begin
            m_state = 1; m_ptr = 0; m_cnt = 0; m_ovf = 1'b0;
            for (int i = 0; i < 32; i++) m_mem1[i] = '0;
            sb.delete();
        end else if (v && exp_rdy) begin
            wd = {w, b, a, op};
            m_mem1[m_ptr] = wd;
            m_mem2[m_ptr] = wd;
            e.idx = m_ptr; e.word = wd;
            sb.push_back(e);
            m_cnt++;
            if (last) begin
                m_state = 2;
            end else if (m_ptr == 31) begin
                m_ovf = 1'b1;
                m_state = 2;
            end else begin
                m_ptr++;
            end
        end
        ld_valid = 1'b0;
        start    = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic beat(input logic last, input int n);
        step(1'b1, 1'b0, last, 5'(n), 5'(n + 1), 5'(n + 2), 5'(n + 3));
    endtask

    task automatic do_start();
        step(1'b0, 1'b1, 1'b0, '0, '0, '0, '0);
    endtask

    initial begin
        int acc;
        logic v;
        rst_n = 1'b0; start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
        ld_opcode = '0; ld_addrA = '0; ld_addrB = '0; ld_addrW = '0;
        model_reset();
        #12;
        rst_n = 1'b1;
        #1;
        chk("reset.ld_ready", 32'(ready1), 32'd0);
        check_flags("reset");
        check_mem("reset");

        // 1: three-beat program
        do_start();
        step(1'b1, 1'b0, 1'b0, 5'd1, 5'd2, 5'd3, 5'd4);
        beat(1'b0, 5);
        beat(1'b1, 9);
        chk("t1.word0", 32'(mem1[0]), 32'h20C41);
        check_flags("t1");
        check_mem("t1");
        drain_sb("t1");

        // 2: 32 beats without last, then a 33rd beat must be refused
        do_start();
        for (int i = 0; i < 32; i++) beat(1'b0, i * 7);
        beat(1'b0, 3);
        check_flags("t2");
        check_mem("t2");
        drain_sb("t2");

        // 3: start collides with a valid beat mid-load
        do_start();
        beat(1'b0, 11);
        beat(1'b0, 12);
        step(1'b1, 1'b1, 1'b0, 5'd30, 5'd30, 5'd30, 5'd30);
        check_flags("t3.restart");
        beat(1'b1, 20);
        check_flags("t3");
        check_mem("t3");
        drain_sb("t3");

        // 4: randomly gapped valid, ten accepted beats
        do_start();
        acc = 0;
        for (int k = 0; k < 200 && acc < 10; k++) begin
            v = 1'($urandom_range(0, 1));
            step(v, 1'b0, v && (acc == 9), 5'($urandom), 5'($urandom),
                 5'($urandom), 5'($urandom));
            if (v) acc++;
        end
        chk("t4.accepted", 32'(acc), 32'd10);
        check_flags("t4");
        check_mem("t4");
        drain_sb("t4");

        // 6: reload shorter program; kept store retains the tail
        do_start();
        for (int i = 0; i < 4; i++) beat(i == 3, 17 + i);
        drain_sb("t6.first");
        do_start();
        beat(1'b0, 2);
        beat(1'b1, 6);
        check_flags("t6");
        check_mem("t6");
        drain_sb("t6");

        // 5: sub-cycle reset pulse after five accepted beats
        do_start();
        for (int i = 0; i < 5; i++) beat(1'b0, 24 + i);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("t5.ld_ready", 32'(ready1), 32'd0);
        check_flags("t5");
        check_mem("t5");
        rst_n = 1'b1;
        #1;
        check_flags("t5.release");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
